// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, constants and FSM encoding for the instruction-fetch stage.
package instr_fetch_pkg;
   localparam int DEF_XLEN = 32;
   localparam int DEF_ADDR_W = 8;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;
endpackage

// File: rtl/instr_fetch.sv
// instr_fetch: PC register, ROM word addressing and IF/ID output register with valid/ready,
// branch redirects and halt on misaligned or out-of-range PCs.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int XLEN = DEF_XLEN,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [XLEN-1:0]   rom_data,
   input  logic              redirect_valid,
   input  logic [XLEN-1:0]   redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_instr,
   output logic [XLEN-1:0]   out_pc,
   output logic              err_misalign,
   output logic              err_range
);
   state_t r_state, w_next;
   logic [XLEN-1:0] r_pc, r_instr, r_opc;
   logic r_valid, r_mis, r_rng;
   logic w_adv, w_redir, w_mis, w_oor, w_fetch;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= FETCH;
      else     r_state <= w_next;

   always_comb w_next = (w_mis || w_oor) ? HALT : r_state;

   // Range is only checked when a fetch would actually happen, so a stalled output stays intact.
   always_comb begin
      w_adv   = !r_valid || out_ready;
      w_redir = (r_state == FETCH) && redirect_valid;
      w_mis   = w_redir && (redirect_pc[1:0] != 2'b00);
      w_oor   = (r_state == FETCH) && !redirect_valid && w_adv && (r_pc[XLEN-1:ADDR_W+2] != '0);
      w_fetch = (r_state == FETCH) && !redirect_valid && w_adv && !w_oor;
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         r_pc    <= RESET_PC;
         r_valid <= 1'b0;
         r_instr <= '0;
         r_opc   <= '0;
         r_mis   <= 1'b0;
         r_rng   <= 1'b0;
      end else begin
         if (w_redir) begin
            r_valid <= 1'b0;
            if (!w_mis) r_pc <= redirect_pc;
         end else if (w_fetch) begin
            r_instr <= rom_data;
            r_opc   <= r_pc;
            r_valid <= 1'b1;
            r_pc    <= r_pc + XLEN'(4);
         end else if (w_oor || r_state == HALT) begin
            r_valid <= 1'b0;
         end
         if (w_mis) r_mis <= 1'b1;
         if (w_oor) r_rng <= 1'b1;
      end

   assign rom_addr     = r_pc[ADDR_W+1:2];
   assign out_valid    = r_valid;
   assign out_instr    = r_instr;
   assign out_pc       = r_opc;
   assign err_misalign = r_mis;
   assign err_range    = r_rng;
endmodule
